mux_tree_pipe: RTL and testbench
================================

# mux_tree_pipe

Parametrised, pipelined N:1 word multiplexer: a generalisation of the 8:1 one-bit mux tree to `2**SEL_W` inputs of `WIDTH` bits, with one register stage per tree level and a valid/ready handshake with backpressure. It is the read-select path for wide register-file and operand-forwarding datapaths, where a single-cycle combinational tree no longer meets timing.

## Interface
Parameters:
- `WIDTH`, 64, bits per input word and output word (≥1).
- `SEL_W`, 5, select width. Input count `N = 2**SEL_W` is a derived localparam, not overridable. Legal range is `SEL_W` ≥ 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `sel`/`in` hold a request this cycle.
- `in_ready`  out  1  pipe accepts a request this cycle.
- `sel`  in  `SEL_W`  index of the word to select.
- `in`  in  `N*WIDTH`  flattened inputs; word i is `in[i*WIDTH +: WIDTH]`.
- `out_valid`  out  1  `out` holds a result.
- `out_ready`  in  1  consumer takes the result this cycle.
- `out`  out  `WIDTH`  selected word.

## Operation
- Tree structure:
  - Stage k (k = 1..`SEL_W`) holds `N>>k` registered words, a valid bit, and the unconsumed select bits `sel[SEL_W-1:k]`.
  - Stage k resolves select bit `k-1`, LSB first. Word j of stage k is the pair (2j, 2j+1) of stage k-1, choosing 2j+1 when the bit is 1. Stage 0 is the `in` port.
  - Stage `SEL_W` holds one word, which drives `out`. Its valid bit drives `out_valid`.
- Global stall:
  - `advance = !out_valid || out_ready`, and `in_ready = advance`.
  - When `advance` is 1, every stage loads from the stage before it. Stage 1 valid loads `in_valid`.
  - When `advance` is 0, every stage holds, including `out`.
- A request transfers when `in_valid && in_ready`. A result transfers when `out_valid && out_ready`.
- Bubbles:
  - Invalid slots travel with valid = 0.
  - Data registers still load on `advance`. Their contents are don't-care when valid is 0.
- Outputs are registered only. There is no combinational path from `in`/`sel` to `out`.
- `in_ready` depends combinationally on `out_ready`. This is intentional and documented for integrators.

## Timing
- Reset (async assert, synchronous deassert is handled by the system):
  - All valid bits are 0, all data and select registers are 0.
  - So `out_valid`=0, `out`=0, and `in_ready`=1.
- Latency: a request accepted at edge t gives `out_valid`=1 with its result after edge t+`SEL_W-1`, i.e. it is visible in the cycle following edge t+`SEL_W-1`. For `SEL_W`=5, the result is visible 5 cycles after acceptance.
- Throughput: one request per cycle while `out_ready`=1.
- Stall:
  - `out_valid && !out_ready` freezes the whole pipe and sets `in_ready`=0.
  - The held `out` value must not change until it is taken.
- Simultaneous take and accept: when `out_ready`=1 and `in_valid`=1 in the same cycle, both transfers happen. No bubble is inserted.
- Reset mid-operation: all in-flight requests are discarded with no partial output. The first request after reset has the full latency.
- `sel` and `in` are sampled only on transfer. Changes while `in_ready`=0 have no effect.

## Structure
- Shared package `mux_pkg` contains:
  - the `SEL_W`→`N` derivation;
  - a `word_idx(i)` part-select helper, reused by the register-file read ports.
- Sub-module `mux_stage` is one level. It has parameters `WIDTH` and `N_IN`, with ports for `N_IN` words, a valid bit, remaining select bits and `advance`, and outputs `N_IN/2` registered words.
- `mux_tree_pipe` is a generate loop of `SEL_W` instances of `mux_stage` plus the handshake logic.

## Test plan
- Reset: assert `rst_n`=0 mid-stream, with 3 requests in flight → `out_valid`=0, `out`=0, `in_ready`=1. After release, none of the pre-reset results ever appear.
- Sweep: `WIDTH`=64, `SEL_W`=5, word i = `64'hA5A5_0000_0000_0000 | i`. Apply `sel`=0..31 back-to-back with `out_ready`=1 → `out` = word `sel` in issue order, first result 5 cycles after the first accept, then one result per cycle.
- Backpressure: drive `out_ready`=0 for 4 cycles while `out_valid`=1 → `out` is stable, `in_ready`=0, and no request is lost or duplicated when `out_ready` returns to 1.
- Bubbles: `in_valid` pattern 1,0,1,1,0 → `out_valid` shows the same pattern delayed by 5 cycles, with correct data on every valid beat.
- Sampling: change `sel`/`in` while `in_ready`=0 → results reflect only the values present at transfer.
- Edge parameters: `SEL_W`=1, `WIDTH`=1, `in`=2'b10, `sel`=1 → `out`=1 one cycle after accept. Also run a randomised scoreboard at `SEL_W`=3, `WIDTH`=8.

Source files
------------

// File: rtl/mux_tree_pipe_pkg.sv
// Shared sizing helpers for the pipelined mux tree and the register-file read ports.
// Purely constant functions, no logic of its own.
package mux_pkg;

  // Number of selectable words for a given select width.
  function automatic int n_of(input int sel_w);
    return 1 << sel_w;
  endfunction

  // Bit offset of word i inside a flattened bus of width-bit words.
  function automatic int word_idx(input int i, input int width);
    return i * width;
  endfunction

endpackage

// File: rtl/mux_tree_pipe_if.sv
// Request/result bundle of the pipelined N:1 word mux.
// Producer side drives sel/in/in_valid and out_ready; the mux drives the rest.
// in_ready is combinational from out_ready inside the mux.
interface mux_tree_pipe_if
  import mux_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SEL_W = 5
);
  localparam int N = n_of(SEL_W);

  logic               in_valid;
  logic               in_ready;
  logic [SEL_W-1:0]   sel;
  logic [N*WIDTH-1:0] in;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out;

  modport master (
    output in_valid, sel, in, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, sel, in, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/mux_tree_pipe_stage.sv
// One tree level: halves N_IN words to N_IN/2 using the lowest remaining select bit.
// Latency: 1 cycle (registered outputs).
// Backpressure: holds every register while advance_i is low.
module mux_stage
  import mux_pkg::*;
#(
  parameter  int WIDTH = 64,
  parameter  int N_IN  = 2,
  localparam int N_OUT = N_IN / 2,
  localparam int SEL_R = $clog2(N_IN),
  localparam int SEL_O = (SEL_R > 1) ? SEL_R - 1 : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   advance_i,
  input  logic                   vld_i,
  input  logic [SEL_R-1:0]       sel_i,
  input  logic [N_IN*WIDTH-1:0]  dat_i,
  output logic                   vld_o,
  output logic [SEL_O-1:0]       sel_o,
  output logic [N_OUT*WIDTH-1:0] dat_o
);
  logic [N_OUT*WIDTH-1:0] dat_d, dat_q;
  logic                   vld_q;

  // Pairwise select: word j takes odd partner 2j+1 when the resolved bit is 1.
  always_comb begin
    dat_d = '0;
    for (int j = 0; j < N_OUT; j++) begin
      dat_d[word_idx(j, WIDTH) +: WIDTH] = sel_i[0] ? dat_i[word_idx(2*j+1, WIDTH) +: WIDTH]
                                                    : dat_i[word_idx(2*j, WIDTH) +: WIDTH];
    end
  end

  // Data and valid load together; data of an invalid slot is don't-care.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else if (advance_i) begin
      vld_q <= vld_i;
      dat_q <= dat_d;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;

  // Unconsumed select bits travel with the data; the last level has none left.
  if (SEL_R > 1) begin : g_sel
    logic [SEL_O-1:0] sel_q;

    // Drop the bit resolved here and keep the rest for later levels.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sel_q <= '0;
      end else if (advance_i) begin
        sel_q <= sel_i[SEL_R-1:1];
      end
    end

    assign sel_o = sel_q;
  end else begin : g_nosel
    assign sel_o = '0;
  end
endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined 2**SEL_W:1 word mux, one register level per select bit, LSB resolved first.
// Latency: SEL_W cycles from accept to visible result; one request per cycle.
// Backpressure: a held, untaken result stalls every level and drops in_ready (comb. from out_ready).
module mux_tree_pipe
  import mux_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SEL_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_tree_pipe_if.slave bus
);
  localparam int N = n_of(SEL_W);

  logic advance;
  logic unused_sel;

  // Whole pipe moves as one: it advances unless the result is waiting to be taken.
  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  for (genvar k = 1; k <= SEL_W; k++) begin : g_st
    localparam int NI = N >> (k - 1);
    localparam int SR = SEL_W - k + 1;
    localparam int SO = (SR > 1) ? SR - 1 : 1;

    logic                   vld;
    logic [SO-1:0]          sel_r;
    logic [(NI/2)*WIDTH-1:0] dat;

    if (k == 1) begin : g_first
      mux_stage #(.WIDTH(WIDTH), .N_IN(NI)) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .advance_i (advance),
        .vld_i     (bus.in_valid),
        .sel_i     (bus.sel),
        .dat_i     (bus.in),
        .vld_o     (vld),
        .sel_o     (sel_r),
        .dat_o     (dat)
      );
    end else begin : g_next
      mux_stage #(.WIDTH(WIDTH), .N_IN(NI)) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .advance_i (advance),
        .vld_i     (g_st[k-1].vld),
        .sel_i     (g_st[k-1].sel_r),
        .dat_i     (g_st[k-1].dat),
        .vld_o     (vld),
        .sel_o     (sel_r),
        .dat_o     (dat)
      );
    end
  end

  assign bus.out_valid = g_st[SEL_W].vld;
  assign bus.out       = g_st[SEL_W].dat;
  // The final level has no select bits left; its constant-zero select output is intentionally dropped.
  assign unused_sel    = ^g_st[SEL_W].sel_r;
endmodule

// File: tb/tb_mux_tree_pipe.sv
// Bench for mux_tree_pipe at three parameter points (64x32, 8x8, 1x2).
// A slot-queue model per instance predicts out/out_valid/in_ready each cycle.
// Directed phases add literal expectations for latency, order, stalls and reset.
module tb_mux_tree_pipe;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mux_tree_pipe_if #(.WIDTH(64), .SEL_W(5)) ifa ();
  mux_tree_pipe_if #(.WIDTH(8),  .SEL_W(3)) ifb ();
  mux_tree_pipe_if #(.WIDTH(1),  .SEL_W(1)) ifc ();

  mux_tree_pipe #(.WIDTH(64), .SEL_W(5)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  mux_tree_pipe #(.WIDTH(8),  .SEL_W(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  mux_tree_pipe #(.WIDTH(1),  .SEL_W(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  logic [63:0] words_a [32];
  logic [7:0]  words_b [8];
  logic        words_c [2];

  always_comb begin
    ifa.in = '0;
    for (int i = 0; i < 32; i++) ifa.in[i*64 +: 64] = words_a[i];
  end
  always_comb begin
    ifb.in = '0;
    for (int i = 0; i < 8; i++) ifb.in[i*8 +: 8] = words_b[i];
  end
  always_comb begin
    ifc.in = '0;
    for (int i = 0; i < 2; i++) ifc.in[i] = words_c[i];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: each instance is SEL_W slots that all shift on advance; slot[SEL_W-1] is the output.
  bit          mv_a [5];
  logic [63:0] md_a [5];
  bit          mv_b [3];
  logic [7:0]  md_b [3];
  bit          mv_c;
  logic        md_c;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) begin mv_a[i] <= 1'b0; md_a[i] <= '0; end
    end else if (!mv_a[4] || ifa.out_ready) begin
      for (int i = 4; i > 0; i--) begin mv_a[i] <= mv_a[i-1]; md_a[i] <= md_a[i-1]; end
      mv_a[0] <= ifa.in_valid;
      md_a[0] <= words_a[ifa.sel];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin mv_b[i] <= 1'b0; md_b[i] <= '0; end
    end else if (!mv_b[2] || ifb.out_ready) begin
      for (int i = 2; i > 0; i--) begin mv_b[i] <= mv_b[i-1]; md_b[i] <= md_b[i-1]; end
      mv_b[0] <= ifb.in_valid;
      md_b[0] <= words_b[ifb.sel];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv_c <= 1'b0;
      md_c <= 1'b0;
    end else if (!mv_c || ifc.out_ready) begin
      mv_c <= ifc.in_valid;
      md_c <= words_c[ifc.sel];
    end
  end

  // Per-cycle compare against the model plus transfer bookkeeping.
  logic [63:0] res_a [$];
  int nacc_a = 0, nres_a = 0, nacc_b = 0, nres_b = 0, nacc_c = 0, nres_c = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("a_in_ready", 64'(ifa.in_ready), 64'(!mv_a[4] || ifa.out_ready));
      chk("a_out_valid", 64'(ifa.out_valid), 64'(mv_a[4]));
      if (mv_a[4]) chk("a_out", ifa.out, md_a[4]);
      if (ifa.in_valid && ifa.in_ready) nacc_a <= nacc_a + 1;
      if (ifa.out_valid && ifa.out_ready) begin
        res_a.push_back(ifa.out);
        nres_a <= nres_a + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("b_in_ready", 64'(ifb.in_ready), 64'(!mv_b[2] || ifb.out_ready));
      chk("b_out_valid", 64'(ifb.out_valid), 64'(mv_b[2]));
      if (mv_b[2]) chk("b_out", 64'(ifb.out), 64'(md_b[2]));
      if (ifb.in_valid && ifb.in_ready) nacc_b <= nacc_b + 1;
      if (ifb.out_valid && ifb.out_ready) nres_b <= nres_b + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("c_in_ready", 64'(ifc.in_ready), 64'(!mv_c || ifc.out_ready));
      chk("c_out_valid", 64'(ifc.out_valid), 64'(mv_c));
      if (mv_c) chk("c_out", 64'(ifc.out), 64'(md_c));
      if (ifc.in_valid && ifc.in_ready) nacc_c <= nacc_c + 1;
      if (ifc.out_valid && ifc.out_ready) nres_c <= nres_c + 1;
    end
  end

  task automatic sweep_words();
    for (int i = 0; i < 32; i++) words_a[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
  endtask

  task automatic reset_literals(input string tag);
    chk({tag, "_a_out_valid"}, 64'(ifa.out_valid), 64'd0);
    chk({tag, "_a_out"},       ifa.out,            64'd0);
    chk({tag, "_a_in_ready"},  64'(ifa.in_ready),  64'd1);
    chk({tag, "_b_out_valid"}, 64'(ifb.out_valid), 64'd0);
    chk({tag, "_b_out"},       64'(ifb.out),       64'd0);
    chk({tag, "_b_in_ready"},  64'(ifb.in_ready),  64'd1);
    chk({tag, "_c_out_valid"}, 64'(ifc.out_valid), 64'd0);
    chk({tag, "_c_out"},       64'(ifc.out),       64'd0);
    chk({tag, "_c_in_ready"},  64'(ifc.in_ready),  64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  int  base, k, nv, acc0, res0, ndead, ncode;
  int  acc0_b, res0_b, acc0_c, res0_c;
  logic [63:0] held;
  bit  pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    rst_n = 1'b0;
    ifa.in_valid = 1'b0; ifa.sel = '0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.sel = '0; ifb.out_ready = 1'b1;
    ifc.in_valid = 1'b0; ifc.sel = '0; ifc.out_ready = 1'b1;
    sweep_words();
    for (int i = 0; i < 8; i++) words_b[i] = 8'(i);
    words_c[0] = 1'b0;
    words_c[1] = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    reset_literals("por");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Sweep sel = 0..31 back-to-back, ready always high.
    base = res_a.size();
    fork
      begin : stream
        for (int s = 0; s < 32; s++) begin
          @(posedge clk); #1;
          ifa.in_valid = 1'b1;
          ifa.sel = 5'(s);
        end
        @(posedge clk); #1 ifa.in_valid = 1'b0;
      end
      begin : meas
        @(posedge clk); @(negedge clk);
        chk("sweep_first_accept", 64'(ifa.in_ready), 64'd1);
        k = 0;
        while (!ifa.out_valid && k < 20) begin @(negedge clk); k++; end
        chk("sweep_latency", 64'(k), 64'd5);
        nv = 0;
        for (int i = 0; i < 31; i++) begin @(negedge clk); if (ifa.out_valid) nv++; end
        chk("sweep_throughput", 64'(nv), 64'd31);
      end
    join
    for (int i = 0; i < 100 && (res_a.size() - base) < 32; i++) @(negedge clk);
    chk("sweep_count", 64'(res_a.size() - base), 64'd32);
    for (int i = 0; i < 32; i++)
      if (base + i < res_a.size())
        chk("sweep_word", res_a[base+i], 64'hA5A5_0000_0000_0000 | 64'(i));

    // Backpressure with input changes during the stall.
    repeat (4) @(negedge clk);
    base = res_a.size();
    acc0 = nacc_a;
    res0 = nres_a;
    for (int s = 0; s < 8; s++) begin
      @(posedge clk); #1;
      ifa.in_valid = 1'b1;
      ifa.sel = 5'($urandom_range(5, 31));
    end
    @(posedge clk); #1;
    ifa.out_ready = 1'b0;
    ifa.sel = 5'd3;
    words_a[3] = 64'hDEAD_0000_0000_0003;
    held = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) held = md_a[4];
      chk("bp_out_valid", 64'(ifa.out_valid), 64'd1);
      chk("bp_in_ready", 64'(ifa.in_ready), 64'd0);
      chk("bp_out_stable", ifa.out, held);
      if (i == 2) begin
        ifa.sel = 5'd4;
        words_a[4] = 64'hC0DE_0000_0000_0004;
      end
    end
    @(posedge clk); #1 ifa.out_ready = 1'b1;
    for (int s = 0; s < 6; s++) begin
      @(posedge clk); #1;
      ifa.sel = 5'($urandom_range(5, 31));
    end
    @(posedge clk); #1 ifa.in_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("bp_accepts", 64'(nacc_a - acc0), 64'd15);
    chk("bp_results", 64'(nres_a - res0), 64'd15);
    ndead = 0;
    ncode = 0;
    for (int i = base; i < res_a.size(); i++) begin
      if (res_a[i] == 64'hDEAD_0000_0000_0003) ndead++;
      if (res_a[i] == 64'hC0DE_0000_0000_0004) ncode++;
    end
    chk("sample_stall_value_absent", 64'(ndead), 64'd0);
    chk("sample_transfer_value_once", 64'(ncode), 64'd1);

    // Bubble pattern 1,0,1,1,0 reappears SEL_W cycles later.
    sweep_words();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      ifa.in_valid = pat[i];
      ifa.sel = 5'(10 + i);
    end
    @(posedge clk); #1 ifa.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bubble_valid", 64'(ifa.out_valid), 64'(pat[i]));
      if (pat[i]) chk("bubble_data", ifa.out, 64'hA5A5_0000_0000_0000 | 64'(10 + i));
    end

    // Single-level instance: in = 2'b10, sel = 1.
    @(posedge clk); #1;
    ifc.in_valid = 1'b1;
    ifc.sel = 1'b1;
    @(posedge clk); #1 ifc.in_valid = 1'b0;
    @(negedge clk);
    chk("c_literal_valid", 64'(ifc.out_valid), 64'd1);
    chk("c_literal_out", 64'(ifc.out), 64'd1);

    // Reset with three requests in flight.
    for (int i = 20; i < 23; i++) words_a[i] = 64'hFACE_0000_0000_0000 | 64'(i);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      ifa.in_valid = 1'b1;
      ifa.sel = 5'(20 + i);
    end
    @(posedge clk); #1 ifa.in_valid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    reset_literals("midrst");
    res0 = nres_a;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_no_stale", 64'(nres_a - res0), 64'd0);
    sweep_words();
    @(posedge clk); #1;
    ifa.in_valid = 1'b1;
    ifa.sel = 5'd7;
    @(negedge clk);
    chk("midrst_accept", 64'(ifa.in_ready), 64'd1);
    @(posedge clk); #1 ifa.in_valid = 1'b0;
    k = 1;
    @(negedge clk);
    while (!ifa.out_valid && k < 20) begin @(negedge clk); k++; end
    chk("midrst_latency", 64'(k), 64'd5);
    chk("midrst_first_data", ifa.out, 64'hA5A5_0000_0000_0007);
    repeat (5) @(negedge clk);

    // Randomised traffic on all three instances, checked every cycle by the model.
    acc0 = nacc_a; res0 = nres_a;
    acc0_b = nacc_b; res0_b = nres_b;
    acc0_c = nacc_c; res0_c = nres_c;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      ifa.in_valid  = 1'($urandom_range(0, 1));
      ifa.out_ready = ($urandom_range(0, 3) != 0);
      ifa.sel       = 5'($urandom_range(0, 31));
      ifa.in_valid  = ifa.in_valid;
      ifb.in_valid  = 1'($urandom_range(0, 1));
      ifb.out_ready = ($urandom_range(0, 3) != 0);
      ifb.sel       = 3'($urandom_range(0, 7));
      ifc.in_valid  = 1'($urandom_range(0, 1));
      ifc.out_ready = ($urandom_range(0, 3) != 0);
      ifc.sel       = 1'($urandom_range(0, 1));
      for (int i = 0; i < 32; i++) words_a[i] = {$urandom(), $urandom()};
      for (int i = 0; i < 8; i++) words_b[i] = 8'($urandom());
      for (int i = 0; i < 2; i++) words_c[i] = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    ifa.in_valid = 1'b0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.out_ready = 1'b1;
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
    repeat (12) @(negedge clk);
    chk("rand_a_balance", 64'(nres_a - res0), 64'(nacc_a - acc0));
    chk("rand_b_balance", 64'(nres_b - res0_b), 64'(nacc_b - acc0_b));
    chk("rand_c_balance", 64'(nres_c - res0_c), 64'(nacc_c - acc0_c));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
